// File: rtl/rmii_txd_serializer.sv
// rmii_txd_serializer: byte-to-dibit RMII transmit serializer, LSB dibit first, with TX_EN and byte-taken strobe
module rmii_txd_serializer (
  input  logic       I_clk50m,
  input  logic       I_rst,
  input  logic       I_txen,
  input  logic [7:0] I_data,
  output logic [1:0] O_txd,
  output logic       O_txen,
  output logic       isSaveData
);
  logic [1:0] phase;
  logic [5:0] sr;
  assign isSaveData = I_rst && (phase == 2'd0) && I_txen;
  // once loaded, a byte runs through all four phases regardless of I_txen
  always_ff @(posedge I_clk50m or negedge I_rst)
    if (!I_rst) begin
      phase  <= 2'd0;
      sr     <= 6'd0;
      O_txd  <= 2'b00;
      O_txen <= 1'b0;
    end else if (phase == 2'd0) begin
      O_txd  <= I_txen ? I_data[1:0] : 2'b00;
      O_txen <= I_txen;
      sr     <= I_txen ? I_data[7:2] : sr;
      phase  <= I_txen ? 2'd1 : 2'd0;
    end else begin
      O_txd <= sr[1:0];
      sr    <= {2'b00, sr[5:2]};
      phase <= phase + 2'd1;
    end
endmodule

// File: tb/tb_rmii_txd_serializer.sv
// tb_rmii_txd_serializer: scoreboard bench; stimulus queues expected dibits and TX_EN run lengths, monitor checks them
module tb_rmii_txd_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txen = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] txd;
  logic       otxen;
  logic       strobe;
  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q[$];
  int         run_q[$];

  rmii_txd_serializer dut (
    .I_clk50m(clk), .I_rst(rst_n), .I_txen(txen), .I_data(data),
    .O_txd(txd), .O_txen(otxen), .isSaveData(strobe)
  );

  always #10 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // one byte: strobe cycle plus three mid-byte cycles; e0..e3 are the dibits in wire order
  task automatic send(input logic [7:0] d, input logic [1:0] e0, e1, e2, e3,
                      input logic keep, input logic [7:0] nxt, input logic mut, input int run);
    @(negedge clk);
    txen = 1'b1;
    data = d;
    #1 chk("strobe", strobe, 1);
    if (run != 0) run_q.push_back(run);
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      txen = keep;
      if (mut) data = 8'($urandom);
      else if (i == 1) data = nxt;
      #1 chk("no_strobe_mid", strobe, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txen = 1'b0;
      #1 chk("no_strobe_idle", strobe, 0);
    end
  endtask

  initial begin : monitor
    int run = 0;
    forever begin
      @(negedge clk);
      if (otxen) begin
        if (exp_q.size() == 0) chk("extra_dibit", 1, 0);
        else chk("txd", txd, exp_q.pop_front());
        run++;
      end else begin
        if (run != 0) begin
          if (run_q.size() == 0) chk("extra_burst", run, 0);
          else chk("txen_run", run, run_q.pop_front());
          run = 0;
        end
        chk("idle_txd", txd, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    txen = 1'b1;
    data = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_txen", otxen, 0);
    chk("rst_txd", txd, 0);
    chk("rst_strobe", strobe, 0);
    txen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    // single byte D5
    send(8'hD5, 2'b01, 2'b01, 2'b01, 2'b11, 1'b0, 8'h00, 1'b0, 4);
    idle(3);
    // stream 7x55 then D5, one contiguous burst
    for (int i = 0; i < 8; i++)
      send(i < 7 ? 8'h55 : 8'hD5, 2'b01, 2'b01, 2'b01, i < 7 ? 2'b01 : 2'b11,
           i < 7, i < 6 ? 8'h55 : 8'hD5, 1'b0, i == 0 ? 32 : 0);
    idle(3);
    // A3 with I_txen dropped right after the strobe
    send(8'hA3, 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 8'h00, 1'b0, 4);
    idle(3);
    // abort in phase 2: only two dibits reach the wire
    @(negedge clk);
    txen = 1'b1;
    data = 8'hE4;
    #1 chk("abort_strobe", strobe, 1);
    run_q.push_back(2);
    exp_q.push_back(2'b00); exp_q.push_back(2'b01);
    @(negedge clk);
    txen = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_txen", otxen, 0);
    chk("abort_txd", txd, 0);
    chk("abort_strobe_low", strobe, 0);
    @(negedge clk);
    txen = 1'b1;
    data = 8'h0F;
    #1 chk("rst_strobe_forced", strobe, 0);
    txen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h0F, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 4);
    idle(3);
    // 3C with I_data scrambled during phases 1..3
    send(8'h3C, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 8'h00, 1'b1, 4);
    idle(4);
    chk("dibits_left", exp_q.size(), 0);
    chk("bursts_left", run_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
